svm_sched: RTL and testbench
============================

# svm_sched

Sequencer that feeds the space-vector modulator with per-period phase-voltage commands. Buffers upstream (vA, vB, vC) samples in a small FIFO, issues one sample per PWM period over the modulator's in_valid/out_valid handshake, and applies period-length changes only at period boundaries. On underrun it repeats the last issued sample so PWM never stalls once started.

## Interface
- D_WIDTH, 16: width of voltage samples and period top
- DEPTH, 4: FIFO depth in samples, power of two, ≥2
- clk  in  1  clock, all logic on rising edge
- rstb  in  1  synchronous active-low reset
- enable  in  1  allow new periods to be issued
- s_valid  in  1  upstream sample valid
- s_ready  out  1  FIFO can accept; high when count < DEPTH
- s_vA, s_vB, s_vC  in  D_WIDTH each  upstream phase voltages
- cfg_top  in  D_WIDTH  requested period top
- cfg_top_wr  in  1  capture cfg_top into shadow register
- svm_vA, svm_vB, svm_vC  out  D_WIDTH each  voltages to modulator
- svm_top  out  D_WIDTH  period top to modulator
- svm_in_valid  out  1  one-cycle issue pulse to modulator
- svm_out_valid  in  1  modulator period-complete pulse
- busy  out  1  a period is in flight (ISSUE or RUN)
- underrun  out  1  one-cycle pulse when a sample is repeated
- underrun_cnt  out  8  saturating underrun count

## Operation
- FIFO: push on s_valid & s_ready; pop only on issue. Push and pop in the same cycle allowed; count unchanged.
- Shadow top: cfg_top_wr loads shadow; reset value 16'h0400 (truncated/zero-extended to D_WIDTH). svm_top loaded from shadow only on issue.
- have_last flag: set on first issue after reset.
- States:
  - IDLE: if enable & FIFO non-empty: pop, load svm_v* from FIFO head, go ISSUE. Else if enable & have_last & FIFO empty: keep svm_v*, pulse underrun, go ISSUE. Else stay.
  - ISSUE: svm_in_valid = 1 for this cycle only; go RUN.
  - RUN: wait for svm_out_valid; then go IDLE.
- svm_v* and svm_top held constant from issue until next issue; the modulator reads them over several cycles after in_valid.
- enable deasserted mid-period: current period completes normally; no new issue until enable returns. FIFO keeps accepting.
- svm_out_valid outside RUN: ignored.
- cfg_top_wr during RUN: affects next period only.

## Timing
- Reset values: s_ready 1, svm_v* 0, svm_top = shadow reset value, svm_in_valid 0, busy 0, underrun 0, underrun_cnt 0, FIFO empty, have_last 0, state IDLE.
- All outputs registered except s_ready (decoded from registered count).
- Sample accepted at edge E into empty FIFO while IDLE & enable: state ISSUE after E+1, svm_in_valid high for cycle after E+1 (2-edge latency).
- svm_out_valid high in cycle k: IDLE in cycle k+1, svm_in_valid high in cycle k+2 if data or have_last.
- underrun pulses in the same cycle as the ISSUE-entry edge takes effect, i.e. coincident with svm_in_valid.
- FIFO full: s_ready 0; a pop in that cycle does not admit a push the same cycle.
- Reset asserted mid-period: all state returns to reset values on the next edge; svm_in_valid never extends beyond one cycle.

## Configuration
- SVM_SCHED_UNDERRUN_CNT_EN defined: underrun_cnt increments on each underrun pulse, saturates at 255, cleared only by reset.
- Not defined: counter logic omitted, underrun_cnt tied to 0; underrun pulse and hold-last behaviour unchanged.

## Test plan
- Reset, enable=1, push (100,200,300) -> svm_in_valid one cycle 2 edges later, svm_v*=(100,200,300), svm_top=16'h0400, busy=1.
- Push 4 samples while first period runs -> s_ready 0 after 4th; each svm_out_valid pulse yields next in_valid 2 cycles later in FIFO order.
- FIFO empty at period end -> in_valid reissued with previous values, underrun pulse, underrun_cnt 1 (0 with macro undefined).
- cfg_top_wr with 500 during RUN -> svm_top stays 16'h0400 until next issue, then 500.
- enable dropped during RUN -> period ends, no further in_valid, busy 0; re-enable with FIFO data -> issue in 2 cycles.
- rstb low mid-RUN one cycle -> all outputs at reset values, FIFO empty; no issue until new sample pushed.

Source files
------------

// File: rtl/svm_sched_if.sv
// Sample/command bus for svm_sched: upstream FIFO write port plus the
// modulator issue/complete handshake. slave = scheduler side, master = peer side.
interface svm_sched_if #(
  parameter int D_WIDTH = 16
);
  logic                      s_valid;
  logic                      s_ready;
  logic signed [D_WIDTH-1:0] s_vA;
  logic signed [D_WIDTH-1:0] s_vB;
  logic signed [D_WIDTH-1:0] s_vC;
  logic signed [D_WIDTH-1:0] svm_vA;
  logic signed [D_WIDTH-1:0] svm_vB;
  logic signed [D_WIDTH-1:0] svm_vC;
  logic        [D_WIDTH-1:0] svm_top;
  logic                      svm_in_valid;
  logic                      svm_out_valid;

  modport slave (
    input  s_valid, s_vA, s_vB, s_vC, svm_out_valid,
    output s_ready, svm_vA, svm_vB, svm_vC, svm_top, svm_in_valid
  );

  modport master (
    output s_valid, s_vA, s_vB, s_vC, svm_out_valid,
    input  s_ready, svm_vA, svm_vB, svm_vC, svm_top, svm_in_valid
  );
endinterface

// File: rtl/svm_sched.sv
// Per-period command sequencer for the space-vector modulator: FIFO-buffered
// samples, one issue per period, hold-last on underrun. Optional macro: SVM_SCHED_UNDERRUN_CNT_EN.
module svm_sched #(
  parameter int D_WIDTH = 16,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic [D_WIDTH-1:0] cfg_top,
  input  logic               cfg_top_wr,
  svm_sched_if.slave         bus,
  output logic               busy,
  output logic               underrun,
  output logic [7:0]         underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [D_WIDTH-1:0] TOP_RST = D_WIDTH'(16'h0400);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic signed [D_WIDTH-1:0] r_mem_a [DEPTH];
  logic signed [D_WIDTH-1:0] r_mem_b [DEPTH];
  logic signed [D_WIDTH-1:0] r_mem_c [DEPTH];
  logic [AW-1:0]             r_wptr;
  logic [AW-1:0]             r_rptr;
  logic [CW-1:0]             r_count;
  logic [D_WIDTH-1:0]        r_shadow;
  logic                      r_have_last;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_repeat;
  logic                      w_issue;

  // s_ready comes straight from the registered count, so a pop in a full cycle cannot make room for a push.
  assign bus.s_ready = (r_count < CW'(DEPTH));
  assign w_push      = bus.s_valid & bus.s_ready;
  assign w_issue     = w_pop | w_repeat;

  always_ff @(posedge clk) begin
    if (!rstb) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_repeat = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && (r_count != '0)) begin
          w_pop  = 1'b1;
          w_next = ISSUE;
        end else if (enable && r_have_last) begin
          w_repeat = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE:   w_next = RUN;
      RUN:     if (bus.svm_out_valid) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= bus.s_vA;
      r_mem_b[r_wptr] <= bus.s_vB;
      r_mem_c[r_wptr] <= bus.s_vC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue stage: command registers change only on an issue and are held for the whole period.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      bus.svm_vA       <= '0;
      bus.svm_vB       <= '0;
      bus.svm_vC       <= '0;
      bus.svm_top      <= TOP_RST;
      bus.svm_in_valid <= 1'b0;
      busy             <= 1'b0;
      underrun         <= 1'b0;
      r_have_last      <= 1'b0;
      r_shadow         <= TOP_RST;
    end else begin
      bus.svm_in_valid <= w_issue;
      underrun         <= w_repeat;
      busy             <= (w_next != IDLE);
      if (w_pop) begin
        bus.svm_vA <= r_mem_a[r_rptr];
        bus.svm_vB <= r_mem_b[r_rptr];
        bus.svm_vC <= r_mem_c[r_rptr];
      end
      if (w_issue) begin
        bus.svm_top <= r_shadow;
        r_have_last <= 1'b1;
      end
      if (cfg_top_wr) r_shadow <= cfg_top;
    end
  end

`ifdef SVM_SCHED_UNDERRUN_CNT_EN
  logic [7:0] r_ucnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstb)         r_ucnt <= 8'd0;
    else if (w_repeat) r_ucnt <= sat_inc8(r_ucnt);
  end

  assign underrun_cnt = r_ucnt;
`else
  assign underrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_svm_sched.sv
// Randomized scoreboard bench for svm_sched: a queue-based period model predicts
// every issue (values, top, underrun, cycle); a negedge monitor checks the DUT.
module tb_svm_sched;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam logic [DW-1:0] TOP_RST = 16'h0400;

  logic          clk        = 1'b0;
  logic          rstb       = 1'b0;
  logic          enable     = 1'b0;
  logic          cfg_top_wr = 1'b0;
  logic [DW-1:0] cfg_top    = '0;
  logic          busy;
  logic          underrun;
  logic [7:0]    underrun_cnt;

  svm_sched_if #(.D_WIDTH(DW)) bus ();

  svm_sched #(.D_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .enable       (enable),
    .cfg_top      (cfg_top),
    .cfg_top_wr   (cfg_top_wr),
    .bus          (bus),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
  } samp_t;

  typedef struct {
    samp_t         s;
    logic [DW-1:0] top;
    logic          und;
    int            cyc;
  } exp_t;

  samp_t         m_q[$];
  exp_t          sb[$];
  samp_t         m_last      = '0;
  logic [DW-1:0] m_shadow    = TOP_RST;
  logic [DW-1:0] m_top       = TOP_RST;
  bit            m_have_last = 1'b0;
  int            m_phase     = 0;   // 0 idle, 1 issue, 2 run
  int            m_cnt       = 0;
  int            cyc         = 0;
  int            n_cmp       = 0;
  int            n_err       = 0;
  int            r_dly       = -1;
  int            max_dly     = 6;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one issue per period, taken from the sample queue or repeated when it is empty.
  always @(posedge clk) begin
    bit    push;
    samp_t smp;
    exp_t  e;
    cyc++;
    if (!rstb) begin
      m_q.delete();
      m_last      = '0;
      m_shadow    = TOP_RST;
      m_top       = TOP_RST;
      m_have_last = 1'b0;
      m_phase     = 0;
      m_cnt       = 0;
    end else begin
      push  = bus.s_valid && (m_q.size() < DEPTH);
      smp.a = bus.s_vA;
      smp.b = bus.s_vB;
      smp.c = bus.s_vC;
      if (m_phase == 0 && enable && (m_q.size() > 0 || m_have_last)) begin
        e.und = (m_q.size() == 0);
        if (!e.und) m_last = m_q.pop_front();
        e.s   = m_last;
        e.top = m_shadow;
        e.cyc = cyc;
        sb.push_back(e);
        m_top       = m_shadow;
        m_have_last = 1'b1;
        m_phase     = 1;
        if (e.und && m_cnt < 255) m_cnt++;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && bus.svm_out_valid) begin
        m_phase = 0;
      end
      if (push) m_q.push_back(smp);
      if (cfg_top_wr) m_shadow = cfg_top;
    end
  end

  // Modulator stand-in: completes each period after a random delay, with rare stray pulses.
  always @(negedge clk) begin
    bus.svm_out_valid = 1'b0;
    if (r_dly > 0) begin
      r_dly--;
    end else if (r_dly == 0) begin
      bus.svm_out_valid = 1'b1;
      r_dly = -1;
    end else if ($urandom_range(0, 49) == 0) begin
      bus.svm_out_valid = 1'b1;
    end
    if (bus.svm_in_valid === 1'b1) r_dly = $urandom_range(0, max_dly);
  end

  always @(negedge clk) begin
    exp_t e;
    check("busy",    busy,        m_phase != 0);
    check("s_ready", bus.s_ready, m_q.size() < DEPTH);
    check("svm_vA",  {bus.svm_vA}, m_last.a);
    check("svm_vB",  {bus.svm_vB}, m_last.b);
    check("svm_vC",  {bus.svm_vC}, m_last.c);
    check("svm_top", bus.svm_top, m_top);
`ifdef SVM_SCHED_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt, m_cnt);
`else
    check("underrun_cnt", underrun_cnt, 0);
`endif
    if (bus.svm_in_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL in_valid: got %b with no issue expected (cycle %0d)", bus.svm_in_valid, cyc);
      end else begin
        e = sb.pop_front();
        check("issue_cycle",  cyc,      e.cyc);
        check("issue_top",    bus.svm_top, e.top);
        check("issue_vA",     {bus.svm_vA}, e.s.a);
        check("issue_und",    underrun, e.und);
      end
    end else begin
      check("underrun_idle", underrun, 0);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        check("missing_issue_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive_sample(input logic [DW-1:0] a, b, c);
    bus.s_valid = 1'b1;
    bus.s_vA    = a;
    bus.s_vB    = b;
    bus.s_vC    = c;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_vA    = '0;
    bus.s_vB    = '0;
    bus.s_vC    = '0;
    rstb        = 1'b0;
    repeat (3) @(negedge clk);
    rstb   = 1'b1;
    enable = 1'b1;
    drive_sample(16'd100, 16'd200, 16'd300);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      drive_sample(DW'($urandom), DW'($urandom), DW'($urandom));
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    cfg_top     = 16'd500;
    cfg_top_wr  = 1'b1;
    @(negedge clk);
    cfg_top_wr = 1'b0;
    repeat (60) @(negedge clk);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    drive_sample(16'hFFF0, 16'h7FFF, 16'h8000);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 2) == 0) drive_sample(DW'($urandom), DW'($urandom), DW'($urandom));
      else bus.s_valid = 1'b0;
      cfg_top    = DW'($urandom);
      cfg_top_wr = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 300) == 0) enable = ~enable;
      rstb = ($urandom_range(0, 900) != 0);
      @(negedge clk);
    end
    rstb       = 1'b1;
    enable     = 1'b1;
    cfg_top_wr = 1'b0;
    max_dly    = 1;
    drive_sample(16'd7, 16'd8, 16'd9);
    @(negedge clk);
    bus.s_valid = 1'b0;
    repeat (2500) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
